// File: rtl/int_arbiter.sv
// int_arbiter: interrupt source arbiter / sequencer for the Zorro III
// interrupt path.
//
// The block collects NSRC level-sensitive, active-low board interrupt
// requests. It masks and prioritises them and presents one winner at a time
// on int_req / vec_out / grant. The grant is held until the bus logic reports
// the vector fetch (vector_read). After that, the block waits HOLDOFF clocks
// and then arbitrates again.
//
// Ports
//   clk, IORST_n       clock, asynchronous active-low reset
//   src_n[NSRC]        raw interrupt requests (active low, async to clk)
//   FCS_n              Zorro full cycle strobe; request sampling only while high
//   reg_wr/reg_addr/din/dout   register file access (dout is a comb. mux)
//   vector_read        one-clk pulse: CPU fetched the vector of current grant
//   int_req            interrupt request to bus logic (active high)
//   vec_out            vector of the current winner, latched at grant
//   grant              one-hot current winner, zero when none
//   busy               FSM is anywhere but IDLE
//
// Register map
//   0..3 VEC[i]   (26)  entries at or above NSRC read 0, writes ignored
//   4    MASK     (00)  bit i enables source i
//   5    PEND     (ro)  synchronised requests & MASK
//   6    CTRL     (00)  bit0 rr_en
//   7    STAT     (ro)  {state[1:0], 3'b0, win_idx[2:0]}

// Per-source request path: resynchronise the raw request, then mask it.
// The second synchroniser stage is the FCS-gated req register. This gives
// the one-edge request latency the bus timing expects. It also freezes the
// sampled request set for the whole of a Zorro bus cycle.
module int_arbiter_lane (
  input  logic clk,
  input  logic IORST_n,
  input  logic src_n_i,
  input  logic fcs_n_i,
  input  logic mask_i,
  output logic elig_o
);
  logic sync_q;
  logic req_q;

  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      sync_q <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      sync_q <= ~src_n_i;
      if (fcs_n_i) req_q <= sync_q;
    end
  end

  assign elig_o = req_q & mask_i;
endmodule

module int_arbiter #(
  parameter int NSRC    = 4,
  parameter int HOLDOFF = 8
) (
  input  logic            clk,
  input  logic            IORST_n,
  input  logic [NSRC-1:0] src_n,
  input  logic            FCS_n,
  input  logic            reg_wr,
  input  logic [2:0]      reg_addr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  input  logic            vector_read,
  output logic            int_req,
  output logic [7:0]      vec_out,
  output logic [NSRC-1:0] grant,
  output logic            busy
);

  localparam logic [7:0] VEC_RST = 8'd26;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARB    = 2'd1,
    S_ASSERT = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  // Register file
  logic [7:0]      vec_q [4];
  logic [NSRC-1:0] mask_q;
  logic            rr_en_q;

  // Sequencer state and registered outputs
  state_e          state_q;
  logic            int_req_q;
  logic [NSRC-1:0] grant_q;
  logic [7:0]      vec_out_q;
  logic [2:0]      win_idx_q;
  logic [2:0]      ptr_q;
  logic [7:0]      cnt_q;

  logic [NSRC-1:0] elig;

  // ---------------------------------------------------------------------------
  // Request lanes
  // ---------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < NSRC; gi++) begin : g_lane
    int_arbiter_lane u_lane (
      .clk     (clk),
      .IORST_n (IORST_n),
      .src_n_i (src_n[gi]),
      .fcs_n_i (FCS_n),
      .mask_i  (mask_q[gi]),
      .elig_o  (elig[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Register file writes. VEC slots at or above NSRC are never written, so
  // they keep VEC_RST and fold away.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      for (int i = 0; i < 4; i++) vec_q[i] <= VEC_RST;
      mask_q  <= '0;
      rr_en_q <= 1'b0;
    end else if (reg_wr) begin
      for (int i = 0; i < 4; i++)
        if (i < NSRC && reg_addr == 3'(i)) vec_q[i] <= din;
      if (reg_addr == 3'd4) mask_q  <= din[NSRC-1:0];
      if (reg_addr == 3'd6) rr_en_q <= din[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection. The eligible set is rotated so that the search start
  // (ptr in round-robin mode, 0 otherwise) lands on bit 0. The lowest set bit
  // of the rotated vector is then mapped back to a source index.
  // ---------------------------------------------------------------------------
  logic [2:0]        base;
  logic [2*NSRC-1:0] elig_dbl;
  logic [NSRC-1:0]   elig_rot;
  logic [3:0]        sum;
  logic [2:0]        win_d;
  logic [NSRC-1:0]   win_oh_d;
  logic [7:0]        win_vec_d;
  logic [2:0]        ptr_d;

  always_comb begin
    base     = rr_en_q ? ptr_q : 3'd0;
    elig_dbl = {elig, elig} >> base;
    elig_rot = elig_dbl[NSRC-1:0];
    sum      = '0;
    win_d    = '0;
    // Walk high to low so that the lowest rotated position is assigned last.
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (elig_rot[k]) begin
        sum   = {1'b0, base} + 4'(k);
        win_d = (sum >= 4'(NSRC)) ? 3'(sum - 4'(NSRC)) : sum[2:0];
      end
    end
  end

  assign win_oh_d  = {{(NSRC-1){1'b0}}, 1'b1} << win_d;
  // Sources above 3 have no VEC register; they present the default vector.
  assign win_vec_d = win_d[2] ? VEC_RST : vec_q[win_d[1:0]];
  assign ptr_d     = (win_idx_q == 3'(NSRC - 1)) ? 3'd0 : win_idx_q + 3'd1;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q   <= S_IDLE;
      int_req_q <= 1'b0;
      grant_q   <= '0;
      vec_out_q <= VEC_RST;
      win_idx_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|elig) state_q <= S_ARB;
        end
        S_ARB: begin
          // The set can empty in the cycle between IDLE and ARB.
          if (|elig) begin
            state_q   <= S_ASSERT;
            int_req_q <= 1'b1;
            grant_q   <= win_oh_d;
            win_idx_q <= win_d;
            vec_out_q <= win_vec_d;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ASSERT: begin
          // A vector fetch takes precedence over a same-edge withdrawal.
          if (vector_read) begin
            state_q   <= S_HOLD;
            int_req_q <= 1'b0;
            grant_q   <= '0;
            cnt_q     <= 8'(HOLDOFF);
            ptr_q     <= ptr_d;
          end else if (!(|(elig & grant_q)) && FCS_n) begin
            state_q   <= S_IDLE;
            int_req_q <= 1'b0;
            grant_q   <= '0;
          end
        end
        S_HOLD: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign int_req = int_req_q;
  assign grant   = grant_q;
  assign vec_out = vec_out_q;
  assign busy    = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [7:0] mask_ext;
  logic [7:0] pend_ext;

  always_comb begin
    mask_ext = '0;
    mask_ext[NSRC-1:0] = mask_q;
    pend_ext = '0;
    pend_ext[NSRC-1:0] = elig;
    dout = '0;
    case (reg_addr)
      3'd0, 3'd1, 3'd2, 3'd3:
        if (int'(reg_addr) < NSRC) dout = vec_q[reg_addr[1:0]];
      3'd4:    dout = mask_ext;
      3'd5:    dout = pend_ext;
      3'd6:    dout = {7'd0, rr_en_q};
      3'd7:    dout = {state_q, 3'b000, win_idx_q};
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_int_arbiter.sv
// Testbench for int_arbiter. It runs directed scenarios with literal
// expectations, followed by a randomized run. A behavioural model in the
// bench predicts every output, and those predictions are compared on each
// falling clock edge.
module tb_int_arbiter;
  localparam int NSRC    = 4;
  localparam int HOLDOFF = 8;

  logic            clk = 1'b0;
  logic            IORST_n = 1'b0;
  logic [NSRC-1:0] src_n = '1;
  logic            FCS_n = 1'b1;
  logic            reg_wr = 1'b0;
  logic [2:0]      reg_addr = 3'd0;
  logic [7:0]      din = 8'd0;
  logic            vector_read = 1'b0;
  logic [7:0]      dout;
  logic            int_req;
  logic [7:0]      vec_out;
  logic [NSRC-1:0] grant;
  logic            busy;

  int checks = 0;
  int errors = 0;

  int_arbiter #(.NSRC(NSRC), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .IORST_n(IORST_n), .src_n(src_n), .FCS_n(FCS_n),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .din(din), .dout(dout),
    .vector_read(vector_read), .int_req(int_req), .vec_out(vec_out),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Phase is tracked as "who holds the grant" (-1 = none),
  // a remaining hold-off count, and an arbitration-pending flag.
  // ---------------------------------------------------------------------------
  int m_vec [4];
  int m_mask = 0, m_ctrl = 0, m_sync = 0, m_req = 0;
  int m_gnt = -1, m_hold = 0, m_win = 0, m_ptr = 0, m_vout = 26;
  bit m_arb = 1'b0;
  int m_elig, m_base, m_w;
  bit m_found;
  logic [NSRC-1:0] srcinv;
  assign srcinv = ~src_n;

  function automatic int m_state();
    if (m_gnt >= 0) return 2;
    if (m_hold > 0) return 3;
    if (m_arb)      return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_dout(input logic [2:0] a);
    if (a < 3'd4) return (int'(a) < NSRC) ? 32'(m_vec[a[1:0]]) : 32'd0;
    case (a)
      3'd4:    return 32'(m_mask);
      3'd5:    return 32'(m_req & m_mask);
      3'd6:    return 32'(m_ctrl);
      default: return 32'((m_state() << 6) | m_win);
    endcase
  endfunction

  always @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      for (int i = 0; i < 4; i++) m_vec[i] = 26;
      m_mask = 0; m_ctrl = 0; m_sync = 0; m_req = 0;
      m_gnt = -1; m_hold = 0; m_win = 0; m_ptr = 0; m_vout = 26; m_arb = 1'b0;
    end else begin
      m_elig = m_req & m_mask;
      if (m_gnt >= 0) begin
        if (vector_read) begin
          m_ptr  = (m_gnt + 1) % NSRC;
          m_hold = HOLDOFF;
          m_gnt  = -1;
        end else if (((m_elig >> m_gnt) & 1) == 0 && FCS_n) begin
          m_gnt = -1;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (m_arb) begin
        m_arb = 1'b0;
        if (m_elig != 0) begin
          m_base  = m_ctrl ? m_ptr : 0;
          m_found = 1'b0;
          for (int k = 0; k < NSRC; k++) begin
            m_w = (m_base + k) % NSRC;
            if (!m_found && ((m_elig >> m_w) & 1) == 1) begin
              m_found = 1'b1;
              m_gnt   = m_w;
            end
          end
          m_win  = m_gnt;
          m_vout = m_vec[m_gnt[1:0]];
        end
      end else if (m_elig != 0) begin
        m_arb = 1'b1;
      end
      if (reg_wr) begin
        if (reg_addr < 3'd4) begin
          if (int'(reg_addr) < NSRC) m_vec[reg_addr[1:0]] = int'(din);
        end else if (reg_addr == 3'd4) m_mask = int'(din) & ((1 << NSRC) - 1);
        else if (reg_addr == 3'd6) m_ctrl = int'(din[0]);
      end
      if (FCS_n) m_req = m_sync;
      m_sync = int'(srcinv);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("int_req", 32'(int_req), 32'(m_gnt >= 0));
    chk("grant", 32'(grant), (m_gnt >= 0) ? 32'(1 << m_gnt) : 32'd0);
    chk("vec_out", 32'(vec_out), 32'(m_vout));
    chk("busy", 32'(busy), 32'(m_state() != 0));
    chk("dout", 32'(dout), model_dout(reg_addr));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 time unit after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; din = d;
    tick(1);
    reg_wr = 1'b0;
  endtask

  task automatic pulse_vr();
    vector_read = 1'b1;
    tick(1);
    vector_read = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
    reg_addr = a;
    #1;
    chk(nm, 32'(dout), 32'(exp));
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (int_req !== 1'b1 && n < 40) begin tick(1); n++; end
    chk(nm, 32'(int_req), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin tick(1); n++; end
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    tick(2);
    // Reset state
    chk("rst int_req", 32'(int_req), 32'd0);
    chk("rst grant", 32'(grant), 32'd0);
    chk("rst vec_out", 32'(vec_out), 32'd26);
    chk("rst busy", 32'(busy), 32'd0);
    rd_chk("rst VEC0", 3'd0, 8'd26);
    rd_chk("rst MASK", 3'd4, 8'h00);
    IORST_n = 1'b1;
    tick(1);

    // Fixed priority: src0 and src2 together, src0 wins
    wr(3'd4, 8'h0F); wr(3'd0, 8'h40); wr(3'd2, 8'h42);
    src_n = 4'b1010;
    tick(3);
    chk("fp int_req before E+3", 32'(int_req), 32'd0);
    tick(1);
    chk("fp int_req at E+3", 32'(int_req), 32'd1);
    chk("fp grant", 32'(grant), 32'h1);
    chk("fp vec_out", 32'(vec_out), 32'h40);
    pulse_vr();
    chk("fp int_req after fetch", 32'(int_req), 32'd0);
    rd_chk("fp STAT hold", 3'd7, 8'hC0);
    tick(9);
    chk("fp int_req in holdoff", 32'(int_req), 32'd0);
    tick(1);
    chk("fp int_req regrant", 32'(int_req), 32'd1);
    chk("fp regrant grant", 32'(grant), 32'h1);

    // Asynchronous reset in the middle of ASSERT
    #2;
    IORST_n = 1'b0;
    #1;
    chk("mid rst int_req", 32'(int_req), 32'd0);
    chk("mid rst grant", 32'(grant), 32'd0);
    chk("mid rst vec_out", 32'(vec_out), 32'd26);
    rd_chk("mid rst MASK", 3'd4, 8'h00);
    rd_chk("mid rst STAT", 3'd7, 8'h00);
    tick(1);
    IORST_n = 1'b1;
    tick(1);

    // Round-robin with all four sources requesting
    wr(3'd4, 8'h0F); wr(3'd6, 8'h01);
    src_n = 4'b0000;
    begin
      logic [3:0] order [5];
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;
      for (int i = 0; i < 5; i++) begin
        wait_req("rr wait");
        chk($sformatf("rr grant %0d", i), 32'(grant), 32'(order[i]));
        pulse_vr();
      end
    end

    // Withdrawal while FCS_n is low, then released when FCS_n goes high
    wait_req("wd wait");
    chk("wd grant src1", 32'(grant), 32'h2);
    FCS_n = 1'b0;
    src_n = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("wd int_req held", 32'(int_req), 32'd1);
    end
    FCS_n = 1'b1;
    tick(2);
    chk("wd int_req dropped", 32'(int_req), 32'd0);
    rd_chk("wd STAT idle", 3'd7, 8'h01);
    src_n = 4'b0000;
    wait_req("wd regrant wait");
    chk("wd ptr unchanged", 32'(grant), 32'h2);

    // Register isolation: VEC0 written while src0 is granted
    pulse_vr();
    src_n = 4'b1110;
    wr(3'd6, 8'h00);
    wait_req("iso wait");
    chk("iso grant", 32'(grant), 32'h1);
    chk("iso vec_out old", 32'(vec_out), 32'd26);
    wr(3'd0, 8'h55);
    chk("iso vec_out kept", 32'(vec_out), 32'd26);
    rd_chk("iso VEC0 read", 3'd0, 8'h55);
    pulse_vr();
    wait_req("iso regrant wait");
    chk("iso vec_out new", 32'(vec_out), 32'h55);

    // Fetch and withdrawal on the same edge: fetch wins, ptr advances
    src_n = 4'b1101;
    pulse_vr();
    wait_req("sim wait");
    chk("sim grant src1", 32'(grant), 32'h2);
    src_n = 4'b1111;
    vector_read = 1'b1;
    tick(1);
    vector_read = 1'b0;
    rd_chk("sim STAT hold", 3'd7, 8'hC1);
    wr(3'd6, 8'h01);
    src_n = 4'b0000;
    wait_req("sim regrant wait");
    chk("sim ptr advanced", 32'(grant), 32'h4);

    // vector_read in IDLE has no effect
    src_n = 4'b1111;
    pulse_vr();
    wait_idle("idle wait");
    pulse_vr();
    chk("idle vr busy", 32'(busy), 32'd0);
    tick(2);
    chk("idle vr int_req", 32'(int_req), 32'd0);
    chk("idle vr busy later", 32'(busy), 32'd0);

    // Randomized run against the model
    wr(3'd4, 8'h0F);
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        IORST_n = 1'b0;
        tick(1);
        IORST_n = 1'b1;
        wr(3'd4, 8'h0F);
      end
      r = $urandom;
      if (r[2:0] == 3'd0) src_n = r[NSRC+7:8];
      FCS_n       = ($urandom_range(0, 3) != 0);
      vector_read = int_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      reg_addr    = 3'($urandom_range(0, 7));
      reg_wr      = ($urandom_range(0, 11) == 0);
      din         = 8'($urandom);
      tick(1);
    end
    reg_wr = 1'b0;
    vector_read = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
